// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI mode-0 (CPOL=0, CPHA=0) transmit engine.
// Serializes one DATA_W-bit command word onto mosi_o and generates
// csn_o and sclk_o for the ADC/DAC front end.
// Define SPI_TX_LSB_FIRST_EN to send the word LSB first; the default is MSB first.
// Legal parameters: DATA_W 2..64, CLK_DIV 1..255 (SCLK half-period in clk_i cycles).
module spi_tx_master #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 50
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              csn_o,
  output logic              busy_o,
  output logic              eot_o,
  output logic              done_o
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic               last_q, last_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               csn_q, csn_d;
  logic               busy_q, busy_d;
  logic               eot_q, eot_d;
  logic               done_q, done_d;

  logic               tick;
  logic [DATA_W-1:0]  sr_shift;
  logic               first_bit;
  logic               next_bit;

  assign tick = (div_cnt_q == DIV_LAST);

`ifdef SPI_TX_LSB_FIRST_EN
  assign sr_shift  = sr_q >> 1;
  assign first_bit = data_i[0];
  assign next_bit  = sr_q[1];
`else
  assign sr_shift  = sr_q << 1;
  assign first_bit = data_i[DATA_W-1];
  assign next_bit  = sr_q[DATA_W-2];
`endif

  // Next-state and next-output logic; every phase lasts CLK_DIV cycles and
  // all transitions happen on the divider tick, so div_cnt restarts at 0
  // at the start of each phase. last_q remembers that the final bit has
  // already been presented on a rising edge.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    busy_d    = busy_q;
    eot_d     = eot_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        last_d    = 1'b0;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
        csn_d     = 1'b1;
        busy_d    = 1'b0;
        eot_d     = 1'b1;
        if (strt_i) begin
          state_d = ST_SETUP;
          sr_d    = data_i;
          mosi_d  = first_bit;
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          eot_d   = 1'b0;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end

      ST_HIGH: begin
        if (tick) begin
          state_d = ST_LOW;
          sclk_d  = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            sr_d      = sr_shift;
            mosi_d    = next_bit;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            last_d = 1'b1;
          end
        end
      end

      ST_LOW: begin
        if (tick) begin
          if (last_q) begin
            state_d = ST_GAP;
            csn_d   = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
            sclk_d  = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          eot_d   = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        sr_d      = '0;
        last_d    = 1'b0;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
        csn_d     = 1'b1;
        busy_d    = 1'b0;
        eot_d     = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      busy_q    <= 1'b0;
      eot_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
      busy_q    <= busy_d;
      eot_q     <= eot_d;
      done_q    <= done_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign csn_o  = csn_q;
  assign busy_o = busy_q;
  assign eot_o  = eot_q;
  assign done_o = done_q;

endmodule
